regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data width of one register-file write.
REQ-002 Parameter ADDR_WIDTH, default 5, register-file address width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 a_valid  input  1  requester A presents a write.
REQ-006 a_addr  input  ADDR_WIDTH  requester A destination register.
REQ-007 a_data  input  WIDTH  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid, b_addr, b_data, b_ready  same widths and directions as A  requester B.
REQ-010 rf_busy  input  1  register file cannot take a write this cycle.
REQ-011 rf_wrenable  output  1  write strobe to register file.
REQ-012 rf_addr  output  ADDR_WIDTH  register-file write address.
REQ-013 rf_data  output  WIDTH  register-file write data.

Function
REQ-014 The block SHALL contain one output stage: out_valid, out_addr, out_data registers; rf_addr/rf_data SHALL drive out_addr/out_data directly.
REQ-015 rf_wrenable SHALL equal out_valid AND NOT rf_busy (combinational).
REQ-016 The stage SHALL be loadable (load_ok) when out_valid is 0 or rf_busy is 0.
REQ-017 A transfer on X SHALL occur when X_valid AND X_ready; X_ready SHALL be load_ok AND grant_X, and SHALL NOT depend on X_valid of the other requester beyond arbitration.
REQ-018 Arbitration SHALL be round-robin: one valid requester wins alone; both valid -> winner is the one not served by the previous transfer; pointer rr SHALL update only on a transfer.
REQ-019 At most one transfer per cycle; the loser SHALL keep its request and win the next loadable cycle.
REQ-020 On transfer, out_valid/out_addr/out_data SHALL load the winner's request at the next edge (one-cycle latency request->rf_wrenable).
REQ-021 If out_valid and not rf_busy and no transfer, out_valid SHALL clear at the next edge.
REQ-022 While rf_busy is 1, the stage SHALL hold its contents unchanged and both ready outputs SHALL be 0 if out_valid is 1.
REQ-023 Back-to-back transfers SHALL sustain one write per cycle when rf_busy stays 0.
REQ-024 Same-address requests from A and B SHALL be written in grant order; the later grant's data SHALL be final.

Reset
REQ-025 While rst_n is 0: out_valid=0, out_addr=0, out_data=0, rr points to A (A wins the first tie), a_ready=b_ready=0, rf_wrenable=0.
REQ-026 Reset asserted mid-write SHALL discard the held write; no rf_wrenable SHALL occur for it after release.
REQ-027 The first transfer SHALL be possible in the first cycle after rst_n rises.

Configuration
REQ-028 Macro ZERO_FILTER_EN: when defined, a transfer with address 0 SHALL be accepted (ready asserted normally, rr updated) but SHALL NOT set out_valid, so no rf_wrenable is issued.
REQ-029 Without ZERO_FILTER_EN, address-0 transfers SHALL be forwarded like any other address.

Structure
REQ-030 A shared package SHALL hold WIDTH/ADDR_WIDTH defaults, the zero-register address constant, and the requester-select enum (REQ_A, REQ_B).
REQ-031 The round-robin grant logic SHALL be one sub-module, rr_arbiter2 (inputs two valids, advance, rst_n, clk; outputs one-hot grant).

Verification
REQ-032 A only: a_valid=1, a_addr=5, a_data=0xDEADBEEF, rf_busy=0 -> a_ready=1 same cycle; next cycle rf_wrenable=1, rf_addr=5, rf_data=0xDEADBEEF.
REQ-033 Tie after reset: A(addr 3, 0x11) and B(addr 4, 0x22) held valid 2 cycles -> writes in order addr 3 then addr 4, on consecutive cycles; rr then favors A.
REQ-034 Stall: out_valid with addr 7, rf_busy=1 for 3 cycles -> rf_wrenable=0, a_ready=b_ready=0, rf_addr stays 7; rf_busy=0 -> single write of addr 7.
REQ-035 Zero register: a_addr=0, a_data=0xFFFFFFFF -> a_ready=1; with ZERO_FILTER_EN no rf_wrenable follows; without it rf_wrenable=1, rf_addr=0.
REQ-036 Reset mid-operation: rst_n=0 while out_valid=1 (addr 9) -> rf_wrenable drops to 0 immediately, no write of addr 9 after release.
REQ-037 Same address: A and B both target addr 12 with 0xA and 0xB -> two writes, last rf_data matches the second grant.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: default widths,
// the hard-wired zero register address and the requester-select encoding.
package regfile_wr_arbiter_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  // Register 0 is the architectural zero register.
  localparam int ZERO_REG_ADDR  = 0;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_sel_e;

endpackage

// File: rtl/regfile_wr_arbiter_rr.sv
// Two-way round-robin arbiter (rr_arbiter2). The priority pointer names the
// requester that wins a tie and moves only when a granted request transfers.
module rr_arbiter2
  import regfile_wr_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     valid_a,
  input  logic     valid_b,
  input  logic     advance,
  output logic [1:0] grant,
  output req_sel_e prio
);

  // A lone requester wins outright; on a tie the pointer decides.
  // No grant is issued while reset is held.
  always_comb begin
    grant = 2'b00;
    if (rst_n) begin
      if (valid_a && (!valid_b || (prio == REQ_A))) begin
        grant = 2'b01;
      end else if (valid_b) begin
        grant = 2'b10;
      end
    end
  end

  // After serving one side, the other side is favoured on the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= REQ_A;
    end else if (advance) begin
      prio <= grant[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Arbitrates two register-file write requesters into a single output stage.
// Optional macro ZERO_FILTER_EN: accepted writes to register 0 are dropped.
module regfile_wr_arbiter
  import regfile_wr_arbiter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_valid,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [WIDTH-1:0]      a_data,
  output logic                  a_ready,
  input  logic                  b_valid,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [WIDTH-1:0]      b_data,
  output logic                  b_ready,
  input  logic                  rf_busy,
  output logic                  rf_wrenable,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [WIDTH-1:0]      rf_data,
  output req_sel_e              rr_ptr
);

  // Handshake: a requester holds valid/addr/data stable until it sees ready
  // in the same cycle; valid && ready is a transfer, captured at the next
  // posedge. ready is asserted only for the arbitration winner, only when
  // the output stage can load, and never while reset is held.

  logic                  out_valid;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic [WIDTH-1:0]      out_data;

  logic                  load_ok;
  logic [1:0]            grant;
  logic                  a_xfer;
  logic                  b_xfer;
  logic                  xfer;
  req_sel_e              win_sel;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;
  logic                  win_fwd;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_a (a_valid),
    .valid_b (b_valid),
    .advance (xfer),
    .grant   (grant),
    .prio    (rr_ptr)
  );

  assign load_ok = !out_valid || !rf_busy;
  assign a_ready = load_ok && grant[0];
  assign b_ready = load_ok && grant[1];
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;
  assign xfer    = a_xfer || b_xfer;

  always_comb begin
    win_sel  = b_xfer ? REQ_B : REQ_A;
    win_addr = a_addr;
    win_data = a_data;
    if (win_sel == REQ_B) begin
      win_addr = b_addr;
      win_data = b_data;
    end
  end

  // A filtered zero-register write still consumes the handshake and moves
  // the pointer; it simply never becomes visible to the register file.
`ifdef ZERO_FILTER_EN
  assign win_fwd = (win_addr != ADDR_WIDTH'(ZERO_REG_ADDR));
`else
  assign win_fwd = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else if (xfer) begin
      out_valid <= win_fwd;
      out_addr  <= win_addr;
      out_data  <= win_data;
    end else if (!rf_busy) begin
      out_valid <= 1'b0;
    end
  end

  assign rf_wrenable = out_valid && !rf_busy;
  assign rf_addr     = out_addr;
  assign rf_data     = out_data;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: per-scenario tasks with inline
// checks and an expected-write queue compared against observed writes.
module tb_regfile_wr_arbiter;
  import regfile_wr_arbiter_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int EW = AW + W;

  logic          clk;
  logic          rst_n;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic          rf_busy;
  logic          rf_wrenable;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_data;
  req_sel_e      rr_ptr;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] wr_log[$];
  int n_checks = 0;
  int n_fail   = 0;

  regfile_wr_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_busy(rf_busy), .rf_wrenable(rf_wrenable), .rf_addr(rf_addr),
    .rf_data(rf_data), .rr_ptr(rr_ptr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write monitor: every strobe seen by the register file
  always @(posedge clk) begin
    if (rf_wrenable) wr_log.push_back({rf_addr, rf_data});
  end

  // driver tasks
  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    rf_busy = 1'b0;
  endtask

  task automatic drive_a(input logic v, input logic [AW-1:0] ad, input logic [W-1:0] d);
    a_valid = v; a_addr = ad; a_data = d;
  endtask

  task automatic drive_b(input logic v, input logic [AW-1:0] ad, input logic [W-1:0] d);
    b_valid = v; b_addr = ad; b_data = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    drive_a(1'b1, 5'd1, 32'h1);
    drive_b(1'b1, 5'd2, 32'h2);
    #1;
    n_checks++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL reset_a_ready: got %b expected 0", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL reset_b_ready: got %b expected 0", b_ready); end
    n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL reset_wrenable: got %b expected 0", rf_wrenable); end
    n_checks++; if (rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", rf_addr); end
    n_checks++; if (rf_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rf_data); end
    n_checks++; if (rr_ptr !== REQ_A) begin n_fail++; $display("FAIL reset_rr: got %b expected %b", rr_ptr, REQ_A); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  // first cycle after reset release: A alone is accepted immediately
  task automatic test_a_only();
    @(negedge clk);
    drive_a(1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL a_only_ready: got %b expected 1", a_ready); end
    n_checks++; if (b_ready !== 1'b0) begin n_fail++; $display("FAIL a_only_b_ready: got %b expected 0", b_ready); end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    @(negedge clk);
    drive_a(1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (rf_wrenable !== 1'b1) begin n_fail++; $display("FAIL a_only_wren: got %b expected 1", rf_wrenable); end
    n_checks++; if (rf_addr !== 5'd5) begin n_fail++; $display("FAIL a_only_addr: got %h expected 05", rf_addr); end
    n_checks++; if (rf_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL a_only_data: got %h expected deadbeef", rf_data); end
    @(negedge clk);
    #1;
    n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL a_only_clear: got %b expected 0", rf_wrenable); end
  endtask

  task automatic test_tie();
    do_reset();
    drive_a(1'b1, 5'd3, 32'h11);
    drive_b(1'b1, 5'd4, 32'h22);
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL tie1_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    exp_q.push_back({5'd3, 32'h11});
    @(negedge clk);
    #1;
    n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b1) begin n_fail++; $display("FAIL tie2_ready: got a=%b b=%b expected a=0 b=1", a_ready, b_ready); end
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd3 || rf_data !== 32'h11) begin n_fail++; $display("FAIL tie2_write: got en=%b addr=%h data=%h expected en=1 addr=03 data=11", rf_wrenable, rf_addr, rf_data); end
    exp_q.push_back({5'd4, 32'h22});
    @(negedge clk);
    drive_a(1'b0, 5'd0, 32'h0);
    drive_b(1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd4 || rf_data !== 32'h22) begin n_fail++; $display("FAIL tie3_write: got en=%b addr=%h data=%h expected en=1 addr=04 data=22", rf_wrenable, rf_addr, rf_data); end
    n_checks++; if (rr_ptr !== REQ_A) begin n_fail++; $display("FAIL tie3_rr: got %b expected %b", rr_ptr, REQ_A); end
    @(negedge clk);
    drive_a(1'b1, 5'd20, 32'h20);
    drive_b(1'b1, 5'd21, 32'h21);
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL tie4_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    exp_q.push_back({5'd20, 32'h20});
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd20) begin n_fail++; $display("FAIL tie5_write: got en=%b addr=%h expected en=1 addr=14", rf_wrenable, rf_addr); end
    @(negedge clk);
  endtask

  task automatic test_stall();
    @(negedge clk);
    drive_a(1'b1, 5'd7, 32'h77);
    exp_q.push_back({5'd7, 32'h77});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rf_busy = 1'b1;
      drive_a(1'b1, 5'd8, 32'h88);
      drive_b(1'b1, 5'd9, 32'h99);
      #1;
      n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL stall_wren[%0d]: got %b expected 0", i, rf_wrenable); end
      n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d]: got a=%b b=%b expected 0 0", i, a_ready, b_ready); end
      n_checks++; if (rf_addr !== 5'd7) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 07", i, rf_addr); end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd7 || rf_data !== 32'h77) begin n_fail++; $display("FAIL stall_release: got en=%b addr=%h data=%h expected en=1 addr=07 data=77", rf_wrenable, rf_addr, rf_data); end
    @(negedge clk);
    #1;
    n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL stall_single: got %b expected 0", rf_wrenable); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive_a(1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %b expected 1", a_ready); end
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef ZERO_FILTER_EN
    n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL zero_filtered: got %b expected 0", rf_wrenable); end
`else
    exp_q.push_back({5'd0, 32'hFFFFFFFF});
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd0) begin n_fail++; $display("FAIL zero_forward: got en=%b addr=%h expected en=1 addr=00", rf_wrenable, rf_addr); end
`endif
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_a(1'b1, 5'd9, 32'h99);
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd9) begin n_fail++; $display("FAIL rmid_pending: got en=%b addr=%h expected en=1 addr=09", rf_wrenable, rf_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL rmid_drop: got %b expected 0", rf_wrenable); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (rf_wrenable !== 1'b0) begin n_fail++; $display("FAIL rmid_after[%0d]: got %b expected 0", i, rf_wrenable); end
      @(negedge clk);
    end
  endtask

  task automatic test_same_addr();
    do_reset();
    drive_a(1'b1, 5'd12, 32'hA);
    drive_b(1'b1, 5'd12, 32'hB);
    #1;
    n_checks++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin n_fail++; $display("FAIL same1_ready: got a=%b b=%b expected a=1 b=0", a_ready, b_ready); end
    exp_q.push_back({5'd12, 32'hA});
    @(negedge clk);
    drive_a(1'b0, 5'd0, 32'h0);
    #1;
    n_checks++; if (b_ready !== 1'b1) begin n_fail++; $display("FAIL same2_b_ready: got %b expected 1", b_ready); end
    n_checks++; if (rf_addr !== 5'd12 || rf_data !== 32'hA) begin n_fail++; $display("FAIL same2_first: got addr=%h data=%h expected addr=0c data=a", rf_addr, rf_data); end
    exp_q.push_back({5'd12, 32'hB});
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd12 || rf_data !== 32'hB) begin n_fail++; $display("FAIL same3_last: got en=%b addr=%h data=%h expected en=1 addr=0c data=b", rf_wrenable, rf_addr, rf_data); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_a(1'b1, AW'(16 + i), 32'h1000 + i);
      exp_q.push_back({AW'(16 + i), 32'h1000 + i});
      #1;
      n_checks++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, a_ready); end
      if (i > 0) begin
        n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== AW'(15 + i)) begin n_fail++; $display("FAIL b2b_write[%0d]: got en=%b addr=%h expected en=1 addr=%h", i, rf_wrenable, rf_addr, AW'(15 + i)); end
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++; if (rf_wrenable !== 1'b1 || rf_addr !== 5'd19 || rf_data !== 32'h1003) begin n_fail++; $display("FAIL b2b_last: got en=%b addr=%h data=%h expected en=1 addr=13 data=1003", rf_wrenable, rf_addr, rf_data); end
    @(negedge clk);
    @(negedge clk);
  endtask

  // scoreboard: the full ordered write stream must match the expected queue
  task automatic test_scoreboard();
    n_checks++;
    if (wr_log.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL sb_count: got %0d writes expected %0d", wr_log.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++) begin
      n_checks++;
      if (wr_log[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL sb_write[%0d]: got %h expected %h", i, wr_log[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_tie();
    test_stall();
    test_zero_reg();
    test_reset_mid();
    test_same_addr();
    test_back_to_back();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
